// File: rtl/fir_filter_param.sv
// Time-multiplexed signed FIR filter: one MAC per clock over a TAPS-deep delay line, with run-time coefficients.
// The output is produced TAPS+2 clocks after the sample is accepted. Define FIR_SAT_EN to clamp the output instead of wrapping it.
// in_ready is high only in IDLE. The source must hold FIR_input and input_valid until the sample is accepted.
module fir_filter_param #(
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int TAPS   = 50,
    parameter int OUT_W  = 22
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic signed [DATA_W-1:0] FIR_input,
    input  logic                     input_valid,
    output logic                     in_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic signed [OUT_W-1:0]  FIR_output,
    output logic                     output_valid
);
    localparam int AW    = $clog2(TAPS);
    localparam int PW    = DATA_W + COEF_W;
    localparam int ACC_W = PW + AW;

    typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic signed [DATA_W-1:0] x [TAPS];
    logic signed [COEF_W-1:0] h [TAPS];
    logic signed [ACC_W-1:0]  acc;
    logic [AW-1:0]            k;
    logic                     accept;
    logic                     coef_wr;
    logic                     coef_ok;
    logic                     mac_last;
    logic signed [DATA_W-1:0] x_k;
    logic signed [COEF_W-1:0] h_k;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [OUT_W-1:0]  out_red;

    // Addresses past the last tap only exist when TAPS is not a power of two
    if ((1 << AW) == TAPS) begin : g_addr_full
        assign coef_ok = 1'b1;
    end else begin : g_addr_part
        assign coef_ok = (coef_addr < AW'(TAPS));
    end

    assign in_ready = (state == IDLE);
    assign mac_last = (k == AW'(TAPS - 1));

    // Operands are sign-extended to full product width. The low PW bits of the product are exact.
    assign x_k      = x[k];
    assign h_k      = h[k];
    assign prod     = {{COEF_W{x_k[DATA_W-1]}}, x_k} * {{DATA_W{h_k[COEF_W-1]}}, h_k};
    assign prod_ext = {{AW{prod[PW-1]}}, prod};

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    // Clamp the accumulator into the signed OUT_W range. This is a no-op when OUT_W equals ACC_W.
    always_comb begin
        out_red = acc[OUT_W-1:0];
        if (acc > SAT_MAX) begin
            out_red = SAT_MAX[OUT_W-1:0];
        end else if (acc < SAT_MIN) begin
            out_red = SAT_MIN[OUT_W-1:0];
        end
    end
`else
    // Two's-complement wrap: keep the low OUT_W bits of the accumulator
    always_comb begin
        out_red = acc[OUT_W-1:0];
    end
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, and the strobes that may only fire in IDLE
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        coef_wr   = 1'b0;
        case (state)
            IDLE: begin
                coef_wr = coef_we && coef_ok;
                if (input_valid) begin
                    accept    = 1'b1;
                    state_nxt = MAC;
                end
            end
            MAC: begin
                if (mac_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: coefficient port, delay line, MAC accumulator and registered output
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc          <= '0;
            k            <= '0;
            FIR_output   <= '0;
            output_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                h[i] <= '0;
            end
        end else begin
            output_valid <= 1'b0;
            if (coef_wr) begin
                h[coef_addr] <= coef_data;
            end
            if (accept) begin
                for (int i = TAPS - 1; i > 0; i--) begin
                    x[i] <= x[i-1];
                end
                x[0] <= FIR_input;
                acc  <= '0;
                k    <= '0;
            end
            if (state == MAC) begin
                acc <= acc + prod_ext;
                k   <= mac_last ? '0 : k + 1'b1;
            end
            if (state == DONE) begin
                FIR_output   <= out_red;
                output_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fir_filter_param.sv
module tb_fir_filter_param;
    logic              clk = 1'b0;
    logic              rst_n;
    logic signed [7:0] din;
    logic              vld;
    logic              we;
    logic [1:0]        waddr;
    logic signed [7:0] wdata;
    logic              a_rdy, a_ovld, b_rdy, b_ovld;
    logic signed [17:0] a_out;
    logic signed [15:0] b_out;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef FIR_SAT_EN
    localparam int B3 = 32767;
    localparam int B4 = 32767;
`else
    localparam int B3 = -17149;
    localparam int B4 = -1020;
`endif

    always #5 clk = ~clk;

    fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(18)) dut_a (
        .clk(clk), .reset(rst_n), .FIR_input(din), .input_valid(vld), .in_ready(a_rdy),
        .coef_we(we), .coef_addr(waddr), .coef_data(wdata),
        .FIR_output(a_out), .output_valid(a_ovld)
    );

    fir_filter_param #(.DATA_W(8), .COEF_W(8), .TAPS(4), .OUT_W(16)) dut_b (
        .clk(clk), .reset(rst_n), .FIR_input(din), .input_valid(vld), .in_ready(b_rdy),
        .coef_we(we), .coef_addr(waddr), .coef_data(wdata),
        .FIR_output(b_out), .output_valid(b_ovld)
    );

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; vld = 1'b0; we = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr_coef(input logic [1:0] a, input logic signed [7:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
        @(negedge clk);
        we = 1'b0;
    endtask

    task automatic wr_all(input logic signed [7:0] c0, c1, c2, c3);
        wr_coef(2'd0, c0); wr_coef(2'd1, c1); wr_coef(2'd2, c2); wr_coef(2'd3, c3);
    endtask

    // wr_mode: 0 = no write, 1 = write during MAC, 2 = write in the acceptance cycle.
    // lat counts rising edges from the acceptance edge up to the one that raises output_valid.
    task automatic send(input logic signed [7:0] s, input int wr_mode, input logic [1:0] wa,
                        input logic signed [7:0] wd, output int ya, output int yb, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!a_rdy && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        din = s; vld = 1'b1;
        if (wr_mode == 2) begin we = 1'b1; waddr = wa; wdata = wd; end
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        vld = 1'b0; we = 1'b0;
        if (wr_mode == 1) begin we = 1'b1; waddr = wa; wdata = wd; end
        while (!a_ovld && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            we = 1'b0;
        end
        ya = a_out;
        yb = b_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; vld = 1'b0; we = 1'b0; din = '0; waddr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (a_out !== 18'sd0) begin n_bad++; $display("FAIL reset_out got=%0d want=0", a_out); end
        n_cmp++; if (a_ovld !== 1'b0) begin n_bad++; $display("FAIL reset_ovld got=%b want=0", a_ovld); end
        n_cmp++; if (a_rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy got=%b want=1", a_rdy); end
        rst_n = 1'b1;
    endtask

    task automatic test_impulse();
        int smp [5] = '{10, 0, 0, 0, 0};
        int exp [5] = '{10, 20, 30, 40, 0};
        int ya, yb, lat;
        wr_all(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        for (int i = 0; i < 5; i++) begin
            send(8'(smp[i]), 0, 2'd0, 8'sd0, ya, yb, lat);
            n_cmp++; if (ya !== exp[i]) begin n_bad++; $display("FAIL impulse_out[%0d] got=%0d want=%0d", i, ya, exp[i]); end
            n_cmp++; if (lat !== 6) begin n_bad++; $display("FAIL impulse_lat[%0d] got=%0d want=6", i, lat); end
            if (i == 0) begin
                n_cmp++; if (a_rdy !== 1'b1) begin n_bad++; $display("FAIL rdy_with_ovld got=%b want=1", a_rdy); end
                @(negedge clk);
                n_cmp++; if (a_ovld !== 1'b0) begin n_bad++; $display("FAIL ovld_pulse got=%b want=0", a_ovld); end
            end
        end
    endtask

    task automatic test_signed();
        int exp [4] = '{16384, 32768, 49152, 65536};
        int ya, yb, lat;
        do_reset();
        wr_all(-8'sd128, -8'sd128, -8'sd128, -8'sd128);
        for (int i = 0; i < 4; i++) begin
            send(-8'sd128, 0, 2'd0, 8'sd0, ya, yb, lat);
            n_cmp++; if (ya !== exp[i]) begin n_bad++; $display("FAIL signed_out[%0d] got=%0d want=%0d", i, ya, exp[i]); end
        end
    endtask

    task automatic test_sat_wrap();
        int exp_a [4] = '{16129, 32258, 48387, 64516};
        int exp_b [4] = '{16129, 32258, B3, B4};
        int ya, yb, lat;
        do_reset();
        wr_all(8'sd127, 8'sd127, 8'sd127, 8'sd127);
        for (int i = 0; i < 4; i++) begin
            send(8'sd127, 0, 2'd0, 8'sd0, ya, yb, lat);
            n_cmp++; if (ya !== exp_a[i]) begin n_bad++; $display("FAIL wide_out[%0d] got=%0d want=%0d", i, ya, exp_a[i]); end
            n_cmp++; if (yb !== exp_b[i]) begin n_bad++; $display("FAIL narrow_out[%0d] got=%0d want=%0d", i, yb, exp_b[i]); end
        end
    endtask

    // Delay line enters holding 127,127,127,127
    task automatic test_coef_busy();
        int ya, yb, lat;
        wr_all(8'sd1, 8'sd1, 8'sd1, 8'sd1);
        send(8'sd2, 1, 2'd0, 8'sd5, ya, yb, lat);
        n_cmp++; if (ya !== 383) begin n_bad++; $display("FAIL busy_write got=%0d want=383", ya); end
        wr_coef(2'd0, 8'sd5);
        send(8'sd3, 0, 2'd0, 8'sd0, ya, yb, lat);
        n_cmp++; if (ya !== 271) begin n_bad++; $display("FAIL idle_write got=%0d want=271", ya); end
        send(8'sd4, 2, 2'd1, 8'sd10, ya, yb, lat);
        n_cmp++; if (ya !== 179) begin n_bad++; $display("FAIL same_cycle_write got=%0d want=179", ya); end
    endtask

    task automatic test_handshake();
        int smp [3] = '{7, 8, 9};
        int n_acc = 0;
        int n_out = 0;
        int cyc = 0;
        int last_acc = -1;
        wr_all(8'sd1, 8'sd0, 8'sd0, 8'sd0);
        @(negedge clk);
        din = 8'(smp[0]); vld = 1'b1;
        while (n_out < 3 && cyc < 100) begin
            if (a_rdy && vld) begin
                if (last_acc >= 0) begin
                    n_cmp++; if (cyc - last_acc !== 6) begin n_bad++; $display("FAIL hs_period got=%0d want=6", cyc - last_acc); end
                end
                last_acc = cyc;
                n_acc++;
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (n_acc < 3) din = 8'(smp[n_acc]);
            else vld = 1'b0;
            if (a_ovld) begin
                n_cmp++; if (a_out !== 18'(smp[n_out])) begin n_bad++; $display("FAIL hs_out[%0d] got=%0d want=%0d", n_out, a_out, smp[n_out]); end
                n_out++;
            end
        end
        vld = 1'b0;
        n_cmp++; if (n_out !== 3) begin n_bad++; $display("FAIL hs_outputs got=%0d want=3", n_out); end
        n_cmp++; if (n_acc !== 3) begin n_bad++; $display("FAIL hs_accepts got=%0d want=3", n_acc); end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        int ya, yb, lat;
        @(negedge clk);
        din = 8'sd50; vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_cmp++; if (a_out !== 18'sd0) begin n_bad++; $display("FAIL midrst_out got=%0d want=0", a_out); end
        n_cmp++; if (a_rdy !== 1'b1) begin n_bad++; $display("FAIL midrst_rdy got=%b want=1", a_rdy); end
        rst_n = 1'b1;
        repeat (8) begin
            if (a_ovld) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL midrst_ovld got=%0d want=0", pulses); end
        wr_all(8'sd1, 8'sd2, 8'sd3, 8'sd4);
        send(8'sd10, 0, 2'd0, 8'sd0, ya, yb, lat);
        n_cmp++; if (ya !== 10) begin n_bad++; $display("FAIL post_rst_out0 got=%0d want=10", ya); end
        send(8'sd0, 0, 2'd0, 8'sd0, ya, yb, lat);
        n_cmp++; if (ya !== 20) begin n_bad++; $display("FAIL post_rst_out1 got=%0d want=20", ya); end
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_signed();
        test_sat_wrap();
        test_coef_busy();
        test_handshake();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
